// File: rtl/seg_pipe_adder.sv
// Segmented pipelined adder: one SEG_W-bit slice per stage, registered carry between stages.
// Optional subtract support via `define SEG_PIPE_ADDER_SUB_EN (adds the in_sub port).

module seg_pipe_adder_stage #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             vld_i,
  input  logic             c_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  output logic             vld_o,
  output logic             c_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] sum_o
);
  localparam int LSB = K * SEG_W;

  logic [SEG_W:0]   seg_res;
  logic             vld_d, vld_q;
  logic             c_d, c_q;
  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [WIDTH-1:0] sum_d, sum_q;

  always_comb begin
    seg_res = {1'b0, a_i[LSB +: SEG_W]} + {1'b0, b_i[LSB +: SEG_W]}
            + {{SEG_W{1'b0}}, c_i};
    vld_d = vld_q;
    c_d   = c_q;
    a_d   = a_q;
    b_d   = b_q;
    sum_d = sum_q;
    if (adv) begin
      vld_d = vld_i;
      c_d   = seg_res[SEG_W];
      a_d   = a_i;
      b_d   = b_i;
      // Lower slices ride along from earlier stages; this stage fills slice K.
      sum_d = sum_i;
      sum_d[LSB +: SEG_W] = seg_res[SEG_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      c_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else begin
      vld_q <= vld_d;
      c_q   <= c_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
    end
  end

  assign vld_o = vld_q;
  assign c_o   = c_q;
  assign a_o   = a_q;
  assign b_o   = b_q;
  assign sum_o = sum_q;
endmodule

module seg_pipe_adder #(
  parameter  int WIDTH   = 32,
  parameter  int SEG_W   = 8,
  localparam int NUM_SEG = WIDTH / SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SEG_PIPE_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);
  logic                          adv;
  logic [NUM_SEG:0]              vld_pipe;
  logic [NUM_SEG:0]              c_pipe;
  logic [NUM_SEG:0][WIDTH-1:0]   a_pipe;
  logic [NUM_SEG:0][WIDTH-1:0]   b_pipe;
  logic [NUM_SEG:0][WIDTH-1:0]   sum_pipe;
  logic                          unused_tail_ops;

  // Whole pipeline moves as one; a stalled output freezes every stage.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  assign vld_pipe[0] = in_valid;
  assign a_pipe[0]   = in_a;
  assign sum_pipe[0] = '0;
`ifdef SEG_PIPE_ADDER_SUB_EN
  // Subtract travels with the beat as the inverted operand plus forced carry-in.
  assign b_pipe[0] = in_sub ? ~in_b : in_b;
  assign c_pipe[0] = in_sub | in_cin;
`else
  assign b_pipe[0] = in_b;
  assign c_pipe[0] = in_cin;
`endif

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    seg_pipe_adder_stage #(
      .WIDTH (WIDTH),
      .SEG_W (SEG_W),
      .K     (k)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv),
      .vld_i (vld_pipe[k]),
      .c_i   (c_pipe[k]),
      .a_i   (a_pipe[k]),
      .b_i   (b_pipe[k]),
      .sum_i (sum_pipe[k]),
      .vld_o (vld_pipe[k+1]),
      .c_o   (c_pipe[k+1]),
      .a_o   (a_pipe[k+1]),
      .b_o   (b_pipe[k+1]),
      .sum_o (sum_pipe[k+1])
    );
  end

  // Operands leaving the last stage have no consumer; synthesis trims them.
  assign unused_tail_ops = ^{a_pipe[NUM_SEG], b_pipe[NUM_SEG]};

  assign out_valid = vld_pipe[NUM_SEG];
  assign out_sum   = sum_pipe[NUM_SEG];
  assign out_cout  = c_pipe[NUM_SEG];
endmodule

// File: tb/tb_seg_pipe_adder.sv
// Directed bench for seg_pipe_adder at default parameters (WIDTH=32, SEG_W=8, 4 stages).
module tb_seg_pipe_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_cin = 1'b0;
`ifdef SEG_PIPE_ADDER_SUB_EN
  logic        in_sub = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_sum;
  logic        out_cout;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg_pipe_adder #(.WIDTH(32), .SEG_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef SEG_PIPE_ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b0 || out_sum !== 32'h0 || out_cout !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state cyc%0d: got v=%b sum=%h c=%b, want 0/00000000/0",
                 i, out_valid, out_sum, out_cout);
      end
    end
    rst_n = 1'b1;
    in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_cin = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_chk++;
      if (c < 4) begin
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_latency cyc%0d: got out_valid=%b, want 0", c, out_valid);
        end
      end else if (out_valid !== 1'b1 || out_sum !== 32'h3333_3334 || out_cout !== 1'b0) begin
        n_fail++;
        $display("FAIL first_result: got v=%b sum=%h c=%b, want 1/33333334/0",
                 out_valid, out_sum, out_cout);
      end
      tick();
    end
  endtask

  task automatic test_carry();
    in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; in_cin = 1'b0;
    tick();
    in_a = 32'h00FF_00FF; in_b = 32'h0001_0001; in_cin = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_sum !== 32'h0 || out_cout !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_full_ripple: got v=%b sum=%h c=%b, want 1/00000000/1",
               out_valid, out_sum, out_cout);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_sum !== 32'h0100_0101 || out_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_partial: got v=%b sum=%h c=%b, want 1/01000101/0",
               out_valid, out_sum, out_cout);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_no_dup: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_stream();
    logic [32:0] exp_q [16];
    int k_in = 0;
    int k_out = 0;
    logic [31:0] a;
    for (int c = 0; c < 24; c++) begin
      out_ready = 1'b1;
      in_valid = (k_in < 16);
      a = 32'h9E37_79B9 * 32'(k_in + 1);
      in_a = (k_in == 5) ? 32'hFFFF_FFFF : a;
      in_b = (k_in == 5) ? 32'hFFFF_FFFF : (32'h7F4A_7C15 ^ (a << 3));
      in_cin = (k_in % 2) == 1;
      #1;
      if (out_valid && out_ready) begin
        n_chk++;
        if (k_out >= 16) begin
          n_fail++;
          $display("FAIL stream_extra: got result %0d at cyc %0d, want only 16", k_out, c);
        end else if ({out_cout, out_sum} !== exp_q[k_out] || c != 4 + k_out) begin
          n_fail++;
          $display("FAIL stream_beat%0d: got %h at cyc %0d, want %h at cyc %0d",
                   k_out, {out_cout, out_sum}, c, exp_q[k_out], 4 + k_out);
        end
        k_out++;
      end
      if (in_valid && in_ready) begin
        exp_q[k_in] = {1'b0, in_a} + {1'b0, in_b} + {32'h0, in_cin};
        k_in++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_chk++;
    if (k_out != 16) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results, want 16", k_out);
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] exp_q [10];
    logic [31:0] held = '0;
    int k_in = 0;
    int k_out = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 5 && c <= 8);
      in_valid = (k_in < 10);
      in_a = 32'h0101_0101 * 32'(k_in + 3);
      in_b = 32'hF0F0_F0F0 + 32'(k_in * 77);
      in_cin = (k_in % 3) == 0;
      #1;
      if (out_valid && !out_ready) begin
        n_chk++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_in_ready cyc%0d: got %b, want 0", c, in_ready);
        end
        if (c == 5) held = out_sum;
        else begin
          n_chk++;
          if (out_sum !== held) begin
            n_fail++;
            $display("FAIL bp_stall_stable cyc%0d: got %h, want %h", c, out_sum, held);
          end
        end
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (k_out >= 10) begin
          n_fail++;
          $display("FAIL bp_extra: got result %0d, want only 10", k_out);
        end else if ({out_cout, out_sum} !== exp_q[k_out]) begin
          n_fail++;
          $display("FAIL bp_beat%0d: got %h, want %h", k_out, {out_cout, out_sum}, exp_q[k_out]);
        end
        k_out++;
      end
      if (in_valid && in_ready) begin
        exp_q[k_in] = {1'b0, in_a} + {1'b0, in_b} + {32'h0, in_cin};
        k_in++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_chk++;
    if (k_out != 10) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results, want 10", k_out);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'(i + 1); in_b = 32'(i + 10); in_cin = 1'b0;
      tick();
    end
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_flush cyc%0d: got out_valid=%b, want 0", c, out_valid);
      end
      tick();
    end
    in_valid = 1'b1; in_a = 32'h0000_0100; in_b = 32'h0000_00FF; in_cin = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_chk++;
      if (c < 4) begin
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL midreset_latency cyc%0d: got out_valid=%b, want 0", c, out_valid);
        end
      end else if (out_valid !== 1'b1 || out_sum !== 32'h0000_0200 || out_cout !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_result: got v=%b sum=%h c=%b, want 1/00000200/0",
                 out_valid, out_sum, out_cout);
      end
      tick();
    end
  endtask

`ifdef SEG_PIPE_ADDER_SUB_EN
  task automatic test_sub();
    logic [31:0] va [5] = '{32'd5, 32'd7, 32'd10, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] vb [5] = '{32'd7, 32'd5, 32'd20, 32'd3, 32'h1};
    logic        vs [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vc [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [32:0] ve [5] = '{{1'b0, 32'hFFFF_FFFE}, {1'b1, 32'h2}, {1'b0, 32'h1F},
                            {1'b1, 32'h0}, {1'b1, 32'h0}};
    int k_in = 0;
    int k_out = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = 1'b1;
      in_valid = (k_in < 5);
      if (k_in < 5) begin
        in_a = va[k_in]; in_b = vb[k_in]; in_sub = vs[k_in]; in_cin = vc[k_in];
      end
      #1;
      if (out_valid && out_ready) begin
        n_chk++;
        if (k_out >= 5) begin
          n_fail++;
          $display("FAIL sub_extra: got result %0d, want only 5", k_out);
        end else if ({out_cout, out_sum} !== ve[k_out] || c != 4 + k_out) begin
          n_fail++;
          $display("FAIL sub_beat%0d: got %h at cyc %0d, want %h at cyc %0d",
                   k_out, {out_cout, out_sum}, c, ve[k_out], 4 + k_out);
        end
        k_out++;
      end
      if (in_valid && in_ready) k_in++;
      tick();
    end
    in_valid = 1'b0; in_sub = 1'b0;
    n_chk++;
    if (k_out != 5) begin
      n_fail++;
      $display("FAIL sub_count: got %0d results, want 5", k_out);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_carry();
    test_stream();
    test_backpressure();
    test_reset_midflight();
`ifdef SEG_PIPE_ADDER_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
